// File: rtl/bsg_router_traffic_pkg.sv
// bsg_router_traffic_pkg
// Shared definitions for the router traffic endpoint:
//   - state_e          : source FSM states
//   - header_width()   : number of header bits ahead of the payload pattern
//   - pattern_src_bit(): payload rule f; payload bit idx is the inverse of
//                        seq bit (idx mod seq width), i.e. ~seq repeated and
//                        truncated at the MSB.
package bsg_router_traffic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  // Header is dest_x, dest_y, src_x, src_y, seq (LSB first).
  function automatic int header_width(input int xw, input int yw, input int cw);
    return 2 * xw + 2 * yw + cw;
  endfunction

  // Which seq bit (inverted) lands in payload bit idx.
  function automatic int pattern_src_bit(input int idx, input int cw);
    return idx % cw;
  endfunction

endpackage

// File: rtl/bsg_router_traffic_pattern.sv
// bsg_router_traffic_pattern
// Combinational payload generator: seq -> full payload pattern made of
// repeated copies of ~seq, truncated at the MSB.
// Ports:
//   seq     in  seq_width_p      sequence number
//   pattern out pattern_width_p  payload bits above the header
module bsg_router_traffic_pattern
  import bsg_router_traffic_pkg::*;
#(
  parameter int seq_width_p     = 16,
  parameter int pattern_width_p = 220
) (
  input  logic [seq_width_p-1:0]     seq,
  output logic [pattern_width_p-1:0] pattern
);

  for (genvar gi = 0; gi < pattern_width_p; gi++) begin : g_bit
    assign pattern[gi] = ~seq[pattern_src_bit(gi, seq_width_p)];
  end

endmodule

// File: rtl/bsg_router_traffic_endpoint.sv
// bsg_router_traffic_endpoint
// Synthetic traffic source/sink for one ready_and mesh link. The source
// injects num_packets_i addressed flits with a deterministic payload; the sink
// checks every received flit against its destination and payload rule.
// Link layout: {v, ready_and_rev, data[width_p-1:0]}.
// Flit layout (LSB first): dest_x, dest_y, src_x, src_y, seq, pattern.
// Optional feature macro: BSG_ROUTER_TRAFFIC_ENDPOINT_THROTTLE_EN adds gap_i,
// the number of idle cycles inserted after each accepted flit.
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   en_i, clear_i             start request (IDLE only), clear pulse
//   num_packets_i, dest_x_i, dest_y_i   run configuration, sampled on start
//   my_x_i, my_y_i            own coordinates (source field, receive check)
//   link_i / link_o           router link in / out
//   done_o, error_o           status (error_o is sticky)
//   sent/recv/error_count_o   saturating statistic counters
module bsg_router_traffic_endpoint
  import bsg_router_traffic_pkg::*;
#(
  parameter int width_p        = 256,
  parameter int x_cord_width_p = 5,
  parameter int y_cord_width_p = 5,
  parameter int count_width_p  = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      en_i,
  input  logic                      clear_i,
  input  logic [count_width_p-1:0]  num_packets_i,
`ifdef BSG_ROUTER_TRAFFIC_ENDPOINT_THROTTLE_EN
  input  logic [7:0]                gap_i,
`endif
  input  logic [x_cord_width_p-1:0] dest_x_i,
  input  logic [y_cord_width_p-1:0] dest_y_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic [width_p+1:0]        link_i,
  output logic [width_p+1:0]        link_o,
  output logic                      done_o,
  output logic [count_width_p-1:0]  sent_count_o,
  output logic [count_width_p-1:0]  recv_count_o,
  output logic [count_width_p-1:0]  error_count_o,
  output logic                      error_o
);

  localparam int hdr_w   = header_width(x_cord_width_p, y_cord_width_p, count_width_p);
  localparam int pat_w   = width_p - hdr_w;
  localparam int seq_off = 2 * x_cord_width_p + 2 * y_cord_width_p;
  localparam int src_off = x_cord_width_p + y_cord_width_p;
  localparam logic [count_width_p-1:0] cnt_max = '1;

  state_e state, state_next;

  logic [count_width_p-1:0]  seq, last_seq;
  logic [count_width_p-1:0]  sent, recv, errors;
  logic                      error_flag;
  logic [x_cord_width_p-1:0] tx_dest_x;
  logic [y_cord_width_p-1:0] tx_dest_y;
  logic                      tx_v, fire, start, clear_ok, gap_idle;
  logic [pat_w-1:0]          tx_pattern, rx_expect;
  logic [width_p-1:0]        tx_flit, rx_data;
  logic                      rx_v, rx_fail;

  assign start    = (state == IDLE) && en_i;
  // A run in progress cannot be cleared; it always completes.
  assign clear_ok = clear_i && (state != SEND);

`ifdef BSG_ROUTER_TRAFFIC_ENDPOINT_THROTTLE_EN
  logic [7:0] gap_len, gap_cnt;
  assign gap_idle = (gap_cnt == 8'd0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      gap_len <= '0;
      gap_cnt <= '0;
    end else if (start) begin
      gap_len <= gap_i;
      gap_cnt <= '0;
    end else if (fire) begin
      gap_cnt <= gap_len;
    end else if (gap_cnt != 8'd0) begin
      gap_cnt <= gap_cnt - 8'd1;
    end
  end
`else
  assign gap_idle = 1'b1;
`endif

  // ---------------- source ----------------
  assign tx_v = (state == SEND) && gap_idle;
  assign fire = tx_v && link_i[width_p];

  bsg_router_traffic_pattern #(
    .seq_width_p     (count_width_p),
    .pattern_width_p (pat_w)
  ) gen_pattern (
    .seq     (seq),
    .pattern (tx_pattern)
  );

  assign tx_flit = {tx_pattern, seq, my_y_i, my_x_i, tx_dest_y, tx_dest_x};

  // Ready follows reset directly so it is low only while reset is held.
  // Data is zeroed whenever v is low so the link is quiet between flits.
  assign link_o = {tx_v, reset_n_i, tx_v ? tx_flit : {width_p{1'b0}}};

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (en_i) state_next = (num_packets_i != '0) ? SEND : DONE;
      SEND:    if (fire && (seq == last_seq)) state_next = DONE;
      DONE:    if (clear_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_next;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      seq       <= '0;
      last_seq  <= '0;
      tx_dest_x <= '0;
      tx_dest_y <= '0;
    end else if (start) begin
      seq       <= '0;
      last_seq  <= num_packets_i - 1'b1;
      tx_dest_x <= dest_x_i;
      tx_dest_y <= dest_y_i;
    end else if (fire) begin
      seq <= seq + 1'b1;
    end
  end

  // ---------------- sink ----------------
  assign rx_v    = link_i[width_p+1];
  assign rx_data = link_i[width_p-1:0];

  bsg_router_traffic_pattern #(
    .seq_width_p     (count_width_p),
    .pattern_width_p (pat_w)
  ) chk_pattern (
    .seq     (rx_data[seq_off +: count_width_p]),
    .pattern (rx_expect)
  );

  assign rx_fail = (rx_data[0 +: x_cord_width_p] != my_x_i)
                || (rx_data[x_cord_width_p +: y_cord_width_p] != my_y_i)
                || (rx_data[width_p-1:hdr_w] != rx_expect);

  // Source coordinates of received flits are informational only.
  logic unused_rx_src;
  assign unused_rx_src = ^rx_data[src_off +: src_off];

  // ---------------- statistics ----------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sent       <= '0;
      recv       <= '0;
      errors     <= '0;
      error_flag <= 1'b0;
    end else if (clear_ok) begin
      sent       <= '0;
      recv       <= '0;
      errors     <= '0;
      error_flag <= 1'b0;
    end else begin
      if (fire && (sent != cnt_max)) sent <= sent + 1'b1;
      if (rx_v && (recv != cnt_max)) recv <= recv + 1'b1;
      if (rx_v && rx_fail) begin
        error_flag <= 1'b1;
        if (errors != cnt_max) errors <= errors + 1'b1;
      end
    end
  end

  assign done_o        = (state == DONE);
  assign sent_count_o  = sent;
  assign recv_count_o  = recv;
  assign error_count_o = errors;
  assign error_o       = error_flag;

endmodule
